// File: rtl/scatter_prefetch_ctrl.sv
// Read prefetch sequencer: keeps several single-beat AXI reads in flight
// and buffers returned beats for the accelerator scatter handshake.
module scatter_prefetch_ctrl #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 128,
  parameter int BEAT_BYTES      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int COUNT_WIDTH     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] total_beats,
  output logic                   ar_valid,
  output logic [ADDR_WIDTH-1:0]  ar_addr,
  input  logic                   ar_ready,
  input  logic                   r_valid,
  input  logic [DATA_WIDTH-1:0]  r_data,
  input  logic [1:0]             r_resp,
  output logic                   r_ready,
  output logic                   scatter_valid,
  output logic [DATA_WIDTH-1:0]  scatter_data,
  input  logic                   channel_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = COUNT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_total;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_received;
  logic [CW-1:0]         r_consumed;
  logic                  r_arv;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [PW:0]           r_cnt;

  logic                  w_start_ok;
  logic                  w_ar_hs;
  logic                  w_rbeat;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [CW-1:0]         w_out;
  logic [CW-1:0]         w_iss_n;
  logic [CW-1:0]         w_rcv_n;
  logic [CW-1:0]         w_out_n;
  logic [PW:0]           w_cnt_n;
  logic [ADDR_WIDTH-1:0] w_off;

  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_ar_hs    = r_arv && ar_ready;
  assign w_rbeat    = r_valid && r_ready;
  assign w_out      = r_issued - r_received;
  assign w_push     = w_rbeat && (w_out != '0);
  assign w_pop      = scatter_valid && channel_ready;

  // Issue decision uses the counts as they will be after this edge,
  // so ar_valid reflects the freshly updated reservation state.
  assign w_iss_n = r_issued + CW'(w_ar_hs);
  assign w_rcv_n = r_received + CW'(w_push);
  assign w_out_n = w_iss_n - w_rcv_n;
  assign w_cnt_n = r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_issue = (w_iss_n < r_total)
                && (w_out_n < CW'(MAX_OUTSTANDING))
                && ((w_out_n + CW'(w_cnt_n)) < CW'(FIFO_DEPTH));
  assign w_off   = ADDR_WIDTH'(w_iss_n) * ADDR_WIDTH'(BEAT_BYTES);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (total_beats == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if ((r_issued == r_total) && !r_arv)
          w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_consumed == r_total)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    r_ready = 1'b0;
    unique case (r_state)
      S_RUN, S_FLUSH: begin
        busy    = 1'b1;
        r_ready = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign ar_valid      = r_arv;
  assign ar_addr       = r_addr;
  assign error         = r_err;
  assign scatter_valid = (r_cnt != '0);
  assign scatter_data  = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_addr     <= '0;
      r_total    <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_consumed <= '0;
      r_arv      <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_start_ok) begin
      r_base     <= base_addr;
      r_addr     <= base_addr;
      r_total    <= total_beats;
      r_issued   <= '0;
      r_received <= '0;
      r_consumed <= '0;
      r_arv      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_issued   <= w_iss_n;
      r_received <= w_rcv_n;
      if (w_pop)
        r_consumed <= r_consumed + CW'(1);
      // A beat with nothing outstanding is dropped but still flagged.
      if (w_rbeat && ((r_resp != 2'b00) || (w_out == '0)))
        r_err <= 1'b1;
      r_arv <= (r_state == S_RUN) && w_issue;
      if ((r_state == S_RUN) && w_issue)
        r_addr <= r_base + w_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_cnt <= w_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push)
      assert (r_cnt != (PW+1)'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_scatter_prefetch_ctrl.sv
// Randomized bench for scatter_prefetch_ctrl: AXI read slave model,
// address/data scoreboards and a cycle monitor.
`timescale 1ns/1ps
module tb_scatter_prefetch_ctrl;

  localparam int AW    = 64;
  localparam int DW    = 128;
  localparam int CW    = 10;
  localparam int DEPTH = 4;
  localparam int MAXO  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] total_beats;
  logic          ar_valid;
  logic [AW-1:0] ar_addr;
  logic          ar_ready;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_ready;
  logic          scatter_valid;
  logic [DW-1:0] scatter_data;
  logic          channel_ready;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  scatter_prefetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .total_beats   (total_beats),
    .ar_valid      (ar_valid),
    .ar_addr       (ar_addr),
    .ar_ready      (ar_ready),
    .r_valid       (r_valid),
    .r_data        (r_data),
    .r_resp        (r_resp),
    .r_ready       (r_ready),
    .scatter_valid (scatter_valid),
    .scatter_data  (scatter_data),
    .channel_ready (channel_ready),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_of(input logic [63:0] a);
    return {a ^ 64'hA5A5_5A5A_0F0F_F0F0, a * 64'h9E37_79B9_7F4A_7C15};
  endfunction

  function automatic bit issue_ok(input int iss, input int rcv,
                                  input int fifo, input int tot);
    int o;
    o = iss - rcv;
    return (iss < tot) && (o < MAXO) && (o + fifo < DEPTH);
  endfunction

  logic [63:0]  exp_addr[$];
  logic [127:0] exp_data[$];
  int  blk_total = 0;
  bit  exp_err   = 0;
  int  iss_m = 0, rcv_m = 0, fifo_m = 0, cons_m = 0;
  int  max_out = 0, simul = 0, done_cnt = 0;
  bit  ar_hs_f = 0, r_hs_f = 0, rst_seen = 0;
  logic [63:0] ar_addr_f = '0;

  int  lat_lo = 2, lat_hi = 2, arr_pct = 100, cr_mode = 0;
  bit  err_en = 0;
  logic [63:0] err_addr = '0;
  int  cyc = 0;
  logic [63:0] sq_a[$];
  int          sq_t[$];

  // AXI read slave and accelerator sink, driven on the falling edge
  initial begin : drv
    int lat;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0;
    r_resp = 2'b00; channel_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_seen) begin
        sq_a.delete(); sq_t.delete(); rst_seen = 0;
      end else begin
        if (ar_hs_f) begin
          lat = lat_lo + int'($urandom_range(lat_hi - lat_lo, 0));
          sq_a.push_back(ar_addr_f);
          sq_t.push_back(cyc + lat);
        end
        if (r_hs_f && sq_a.size() > 0) begin
          void'(sq_a.pop_front());
          void'(sq_t.pop_front());
        end
      end
      ar_ready = (int'($urandom_range(99, 0)) < arr_pct);
      if (sq_a.size() > 0 && sq_t[0] <= cyc) begin
        r_valid = 1'b1;
        r_data  = beat_of(sq_a[0]);
        r_resp  = (err_en && sq_a[0] == err_addr) ? 2'b10 : 2'b00;
      end else begin
        r_valid = 1'b0;
        r_resp  = 2'b00;
      end
      case (cr_mode)
        0:       channel_ready = 1'b1;
        1:       channel_ready = 1'b0;
        2:       channel_ready = $urandom_range(1, 0) == 1;
        default: channel_ready = (fifo_m == 3 && r_valid && r_ready)
                              || fifo_m >= 4 || rcv_m >= blk_total;
      endcase
    end
  end

  initial begin : mon
    bit   ar_hs, r_hs, s_hs, p_r_hs, p_bad, p_pend;
    int   p_out, out_b, fifo_b;
    logic [63:0]  p_addr, ea;
    logic [127:0] ed;
    p_r_hs = 0; p_bad = 0; p_pend = 0; p_out = 0; p_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_addr.delete(); exp_data.delete();
        iss_m = 0; rcv_m = 0; fifo_m = 0; cons_m = 0;
        rst_seen = 1; ar_hs_f = 0; r_hs_f = 0;
        p_r_hs = 0; p_bad = 0; p_pend = 0; p_out = 0;
      end else begin
        if (start && !busy && !done) begin
          iss_m = 0; rcv_m = 0; fifo_m = 0; cons_m = 0;
          max_out = 0; simul = 0;
        end
        chk(scatter_valid == (fifo_m != 0), "scatter_valid",
            scatter_valid, fifo_m != 0);
        if (busy && ar_valid)
          chk(issue_ok(iss_m, rcv_m, fifo_m, blk_total), "ar_rule",
              iss_m, rcv_m);
        if (p_pend)
          chk(ar_valid && ar_addr == p_addr, "ar_hold", ar_addr, p_addr);
        if (p_r_hs && p_out == MAXO && busy
            && issue_ok(iss_m, rcv_m, fifo_m, blk_total))
          chk(ar_valid, "ar_resume", ar_valid, 1);
        if (p_bad)
          chk(error, "err_set", error, 1);

        ar_hs  = ar_valid && ar_ready;
        r_hs   = r_valid && r_ready;
        s_hs   = scatter_valid && channel_ready;
        out_b  = iss_m - rcv_m;
        fifo_b = fifo_m;
        if (ar_hs) begin
          if (exp_addr.size() == 0) begin
            chk(0, "ar_extra", ar_addr, 0);
          end else begin
            ea = exp_addr.pop_front();
            chk(ar_addr == ea, "ar_addr", ar_addr, ea);
          end
          iss_m++;
        end
        if (r_hs) begin
          rcv_m++;
          fifo_m++;
          chk(fifo_m <= DEPTH, "fifo_bound", fifo_m, DEPTH);
        end
        if (s_hs) begin
          if (exp_data.size() == 0) begin
            chk(0, "scatter_extra", scatter_data, 0);
          end else begin
            ed = exp_data.pop_front();
            chk(scatter_data == ed, "scatter_data", scatter_data, ed);
          end
          fifo_m--;
          cons_m++;
        end
        if (r_hs && s_hs && fifo_b == 3) simul++;
        if (ar_hs) begin
          chk(iss_m - rcv_m <= MAXO, "outstanding", iss_m - rcv_m, MAXO);
          if (iss_m - rcv_m > max_out) max_out = iss_m - rcv_m;
        end
        if (done) begin
          done_cnt++;
          chk(exp_data.size() == 0 && exp_addr.size() == 0, "done_drained",
              exp_data.size(), 0);
          chk(error == exp_err, "done_error", error, exp_err);
          chk(!busy, "done_busy", busy, 0);
        end
        p_pend  = ar_valid && !ar_ready;
        p_addr  = ar_addr;
        p_r_hs  = r_hs;
        p_out   = out_b;
        p_bad   = r_hs && r_resp != 2'b00;
        ar_hs_f = ar_hs;
        ar_addr_f = ar_addr;
        r_hs_f  = r_hs;
      end
    end
  end

  task automatic prep(input logic [63:0] base, input int total,
                      input int err_idx, input int llo, input int lhi,
                      input int arp, input int crm);
    lat_lo = llo; lat_hi = lhi; arr_pct = arp; cr_mode = crm;
    err_en   = (err_idx >= 0) && (err_idx < total);
    err_addr = base + 64'(err_idx) * 64'd16;
    blk_total = total;
    exp_err   = err_en;
    for (int i = 0; i < total; i++) begin
      exp_addr.push_back(base + 64'(i) * 64'd16);
      exp_data.push_back(beat_of(base + 64'(i) * 64'd16));
    end
    @(negedge clk); #1;
    base_addr = base; total_beats = CW'(total); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    base_addr = {$urandom, $urandom};
    total_beats = CW'($urandom_range(700, 1));
  endtask

  task automatic run_block(input logic [63:0] base, input int total,
                           input int err_idx, input int llo, input int lhi,
                           input int arp, input int crm, input int stall,
                           input bit ign);
    int d0, t;
    d0 = done_cnt;
    prep(base, total, err_idx, llo, lhi, arp, (stall > 0) ? 1 : crm);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      #1;
      chk(iss_m == DEPTH, "stall_issued", iss_m, DEPTH);
      chk(fifo_m == DEPTH, "stall_fifo", fifo_m, DEPTH);
      cr_mode = crm;
    end
    if (ign) begin
      repeat (3) @(negedge clk);
      #1;
      chk(busy, "busy_mid", busy, 1);
      start = 1'b1; base_addr = 64'hDEAD_0000; total_beats = CW'(3);
      @(negedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    chk(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk(done_cnt == d0 + 1, "done_once", done_cnt - d0, 1);
    chk(!done && !busy, "idle_after", {done, busy}, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0, t;
    rst = 1'b1; start = 1'b0; base_addr = '0; total_beats = '0;
    repeat (3) @(negedge clk);
    #1;
    chk({ar_valid, r_ready, scatter_valid, busy, done, error} == 6'b0,
        "reset_outputs",
        {ar_valid, r_ready, scatter_valid, busy, done, error}, 0);
    rst = 1'b0;

    run_block(64'h1000, 8, -1, 2, 2, 100, 0, 0, 0);
    run_block(64'h2000, 16, -1, 2, 2, 100, 0, 20, 0);
    run_block(64'h3000, 10, -1, 12, 12, 100, 0, 0, 0);
    chk(max_out == MAXO, "max_outstanding", max_out, MAXO);

    run_block(64'h4000, 6, 3, 1, 3, 70, 2, 0, 0);
    chk(error, "err_sticky", error, 1);
    blk_total = 0; exp_err = 0; err_en = 0;
    d0 = done_cnt;
    @(negedge clk); #1;
    start = 1'b1; total_beats = '0; base_addr = 64'h5000;
    @(negedge clk); #1;
    start = 1'b0;
    chk(done && !busy, "zero_done", {done, busy}, 2'b10);
    chk(!error, "zero_err_clear", error, 0);
    repeat (2) @(negedge clk);
    #1;
    chk(done_cnt == d0 + 1, "zero_done_once", done_cnt - d0, 1);

    prep(64'h8000, 12, 2, 2, 5, 80, 2);
    t = 0;
    while (cons_m != 5 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    chk(cons_m == 5, "rst_wait", cons_m, 5);
    chk(error, "err_pre_rst", error, 1);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk({ar_valid, r_ready, scatter_valid, busy, done, error} == 6'b0,
        "midblock_reset",
        {ar_valid, r_ready, scatter_valid, busy, done, error}, 0);
    repeat (4) @(negedge clk);
    #1;
    chk(done_cnt == d0 && !busy, "rst_no_done", done_cnt - d0, 0);

    run_block(64'h9000, 12, -1, 3, 6, 90, 2, 0, 1);
    run_block(64'h6000, 24, -1, 1, 4, 100, 3, 0, 0);
    chk(simul > 0, "simul_push_pop", simul, 1);
    run_block(64'hFFFF_FFFF_FFFF_FFC0, 8, 5, 1, 4, 80, 2, 0, 0);

    for (int k = 0; k < 5; k++) begin
      int tot;
      tot = int'($urandom_range(30, 1));
      run_block({$urandom, $urandom} & ~64'hF, tot,
                int'($urandom_range(tot + 2, 0)) - 1,
                1, int'($urandom_range(8, 1)),
                int'($urandom_range(100, 30)), 2, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
